// File: rtl/reg_swap_engine.sv
// reg_swap_engine: two-register exchange through TEMP, one register write per clock edge
// Ports: clk/rst_n (async active-low); load/load_a/load_b load A and B while idle;
// swap_req starts a swap while idle; busy is high while a swap is running; done is a
// one-cycle pulse after B is written; a_out/b_out/temp_out give the registers;
// swap_count counts completed swaps and wraps.
module reg_swap_engine #(
  parameter int WIDTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_a,
  input  logic [WIDTH-1:0] load_b,
  input  logic             swap_req,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic [WIDTH-1:0] temp_out,
  output logic [CNT_W-1:0] swap_count
);
  typedef enum logic [1:0] {IDLE, SAVE, MOVE_A, MOVE_B} state_t;
  state_t state;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_out      <= '0;
      b_out      <= '0;
      temp_out   <= '0;
      done       <= 1'b0;
      swap_count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE:
          if (load) begin
            a_out <= load_a;
            b_out <= load_b;
          end else if (swap_req) state <= SAVE;
        SAVE: begin
          temp_out <= a_out;
          state    <= MOVE_A;
        end
        MOVE_A: begin
          a_out <= b_out;
          state <= MOVE_B;
        end
        MOVE_B: begin
          b_out      <= temp_out;
          done       <= 1'b1;
          swap_count <= swap_count + 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_reg_swap_engine.sv
// tb_reg_swap_engine: directed and randomized checks of reg_swap_engine against an exchange model
module tb_reg_swap_engine;
  logic clk = 1'b0, rst_n = 1'b0, load = 1'b0, swap_req = 1'b0;
  logic [1:0] load_a = '0, load_b = '0;
  logic busy, done;
  logic [1:0] a_out, b_out, temp_out;
  logic [7:0] swap_count;
  int errors = 0, checks = 0;
  logic [1:0] ma, mb, mt;
  int mcnt;
  reg_swap_engine #(.WIDTH(2), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .load_a(load_a), .load_b(load_b),
    .swap_req(swap_req), .busy(busy), .done(done), .a_out(a_out), .b_out(b_out),
    .temp_out(temp_out), .swap_count(swap_count)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_regs(input string tag);
    chk({tag, "_a"}, a_out, ma);
    chk({tag, "_b"}, b_out, mb);
    chk({tag, "_t"}, temp_out, mt);
    chk({tag, "_cnt"}, swap_count, mcnt & 255);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_a"}, a_out, 0);
    chk({tag, "_b"}, b_out, 0);
    chk({tag, "_t"}, temp_out, 0);
    chk({tag, "_cnt"}, swap_count, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    ma = 0; mb = 0; mt = 0; mcnt = 0;
    tick();
  endtask
  task automatic do_load(input logic [1:0] a, input logic [1:0] b);
    load = 1'b1; load_a = a; load_b = b;
    tick();
    load = 1'b0;
    ma = a; mb = b;
    chk_regs("load");
  endtask
  task automatic do_swap();
    logic [1:0] oa, ob;
    oa = ma; ob = mb;
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    chk("e0_busy", busy, 1);
    tick();
    chk("e1_temp", temp_out, oa);
    chk("e1_a", a_out, oa);
    tick();
    chk("e2_a", a_out, ob);
    chk("e2_b", b_out, ob);
    chk("e2_done", done, 0);
    tick();
    ma = ob; mb = oa; mt = oa; mcnt++;
    chk("e3_done", done, 1);
    chk("e3_busy", busy, 0);
    chk_regs("e3");
    tick();
    chk("e4_done", done, 0);
  endtask
  initial begin
    int pulses, last;
    ma = 0; mb = 0; mt = 0; mcnt = 0;
    #12;
    chk_zero("por");
    rst_n = 1'b1;
    tick();
    do_load(2'b01, 2'b10);
    do_swap();
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    rst_n = 1'b1;
    ma = 0; mb = 0; mt = 0; mcnt = 0;
    tick();
    do_load(2'b00, 2'b11);
    do_swap();
    do_reset();
    do_load(2'b00, 2'b11);
    swap_req = 1'b1;
    pulses = 0;
    last = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("held_done", done, (i % 4) == 3);
      if (done) begin
        pulses++;
        if (last >= 0) chk("held_gap", i - last, 4);
        last = i;
        {ma, mb} = {mb, ma};
        mt = mb;
        mcnt++;
        chk_regs("held");
      end
    end
    swap_req = 1'b0;
    chk("held_pulses", pulses, 10);
    chk("held_cnt", swap_count, 10);
    tick();
    load = 1'b1; load_a = 2'b01; load_b = 2'b10; swap_req = 1'b1;
    tick();
    load = 1'b0; swap_req = 1'b0;
    ma = 2'b01; mb = 2'b10;
    chk_regs("ld_pri");
    chk("ld_pri_busy", busy, 0);
    tick();
    chk("ld_pri_busy2", busy, 0);
    chk_regs("ld_pri2");
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    tick();
    load = 1'b1; load_a = 2'b11; load_b = 2'b11;
    tick();
    load = 1'b0;
    tick();
    chk("ldmv_done", done, 1);
    chk("ldmv_a", a_out, 2'b10);
    chk("ldmv_b", b_out, 2'b01);
    chk("ldmv_t", temp_out, 2'b01);
    tick();
    do_reset();
    do_load(2'b01, 2'b10);
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    tick();
    chk("mid_temp", temp_out, 2'b01);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("mid_rst");
    rst_n = 1'b1;
    ma = 0; mb = 0; mt = 0; mcnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_zero("post_rst");
    end
    do_load(2'b01, 2'b10);
    do_swap();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) do_load(2'($urandom), 2'($urandom));
      else do_swap();
      if ($urandom_range(0, 1) == 1) begin
        tick();
        chk_regs("idle_hold");
      end
    end
    do_reset();
    do_load(2'b10, 2'b01);
    for (int i = 0; i < 256; i++) do_swap();
    chk("wrap_cnt", swap_count, 0);
    chk("wrap_a", a_out, 2'b10);
    chk("wrap_b", b_out, 2'b01);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
